// File: rtl/spectrogram_stream_receiver.sv
// Host-side deserializer for the spectrogram extractor's two-lane readout stream:
// 32-bit MSB-first timestamp on lane 0, then 3-bit channel code pairs on lanes 0/1.
module spectrogram_stream_receiver #(
  parameter int MAX_SAMPLES = 512,
  localparam int IDX_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1,
  localparam int CNT_W = $clog2(MAX_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       serial_in,
  input  logic             serial_readout,
  input  logic             sending_data,
  output logic [31:0]      event_time,
  output logic             time_valid,
  output logic [2:0]       ch1_code,
  output logic [2:0]       ch2_code,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sample_valid,
  output logic             frame_done,
  output logic             frame_error,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, TIME, DATA, SKIP} state_t;

  state_t state_reg, state_next;

  logic [31:0]      time_sr_reg;
  logic [4:0]       time_cnt_reg;
  logic [1:0][2:0]  ch_sr_reg;
  logic [1:0][2:0]  ch_shifted;
  logic [1:0]       trip_cnt_reg;
  logic [CNT_W-1:0] pair_cnt_reg;
  logic             overflow_reg;

  logic [31:0]      event_time_reg;
  logic             time_valid_reg;
  logic [2:0]       ch1_code_reg;
  logic [2:0]       ch2_code_reg;
  logic [IDX_W-1:0] sample_idx_reg;
  logic             sample_valid_reg;
  logic             frame_done_reg;
  logic             frame_error_reg;
  logic [CNT_W-1:0] sample_count_reg;
  logic             busy_reg;

  logic accept;
  logic frame_start;
  logic frame_end;
  logic time_shift;
  logic time_last;
  logic pairs_full;
  logic data_shift;
  logic pair_last;
  logic overflow_set;

  // Lane gi feeds channel gi+1; each lane's shift register gets its next value here.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_lane
      assign ch_shifted[gi] = {ch_sr_reg[gi][1:0], serial_in[gi]};
    end
  endgenerate

  assign accept       = sending_data & serial_readout;
  assign frame_start  = (state_reg == IDLE) & sending_data;
  assign frame_end    = ((state_reg == TIME) | (state_reg == DATA)) & ~sending_data;
  // The bit accepted in the IDLE->TIME cycle is already timestamp bit 31.
  assign time_shift   = accept & ((state_reg == IDLE) | (state_reg == TIME));
  assign time_last    = accept & (state_reg == TIME) & (time_cnt_reg == 5'd31);
  assign pairs_full   = (pair_cnt_reg == CNT_W'(MAX_SAMPLES));
  assign data_shift   = accept & (state_reg == DATA) & ~pairs_full;
  assign pair_last    = data_shift & (trip_cnt_reg == 2'd2);
  assign overflow_set = accept & (state_reg == DATA) & pairs_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Coming out of reset mid-frame would misalign the stream, so sit it out.
      state_reg <= sending_data ? SKIP : IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (sending_data) state_next = TIME;
      TIME: begin
        if (!sending_data)  state_next = IDLE;
        else if (time_last) state_next = DATA;
      end
      DATA: if (!sending_data) state_next = IDLE;
      SKIP: if (!sending_data) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_sr_reg      <= '0;
      time_cnt_reg     <= '0;
      ch_sr_reg        <= '0;
      trip_cnt_reg     <= '0;
      pair_cnt_reg     <= '0;
      overflow_reg     <= 1'b0;
      event_time_reg   <= '0;
      time_valid_reg   <= 1'b0;
      ch1_code_reg     <= '0;
      ch2_code_reg     <= '0;
      sample_idx_reg   <= '0;
      sample_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_error_reg  <= 1'b0;
      sample_count_reg <= '0;
      busy_reg         <= sending_data;
    end else begin
      time_valid_reg   <= 1'b0;
      sample_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_error_reg  <= 1'b0;
      busy_reg         <= (state_next != IDLE);

      if (frame_start) begin
        time_cnt_reg     <= accept ? 5'd1 : 5'd0;
        trip_cnt_reg     <= '0;
        pair_cnt_reg     <= '0;
        overflow_reg     <= 1'b0;
        sample_count_reg <= '0;
      end else if (time_shift) begin
        time_cnt_reg <= time_cnt_reg + 5'd1;
      end

      if (time_shift) begin
        time_sr_reg <= {time_sr_reg[30:0], serial_in[0]};
      end

      if (time_last) begin
        event_time_reg <= {time_sr_reg[30:0], serial_in[0]};
        time_valid_reg <= 1'b1;
      end

      if (data_shift) begin
        ch_sr_reg <= ch_shifted;
        if (pair_last) begin
          ch1_code_reg     <= ch_shifted[0];
          ch2_code_reg     <= ch_shifted[1];
          sample_idx_reg   <= pair_cnt_reg[IDX_W-1:0];
          sample_valid_reg <= 1'b1;
          pair_cnt_reg     <= pair_cnt_reg + 1'b1;
          trip_cnt_reg     <= '0;
        end else begin
          trip_cnt_reg <= trip_cnt_reg + 2'd1;
        end
      end

      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end

      // A frame ending in TIME never completed its timestamp.
      if (frame_end) begin
        frame_done_reg   <= 1'b1;
        frame_error_reg  <= (state_reg == TIME) | (trip_cnt_reg != 2'd0) | overflow_reg;
        sample_count_reg <= pair_cnt_reg;
      end
    end
  end

  assign event_time   = event_time_reg;
  assign time_valid   = time_valid_reg;
  assign ch1_code     = ch1_code_reg;
  assign ch2_code     = ch2_code_reg;
  assign sample_idx   = sample_idx_reg;
  assign sample_valid = sample_valid_reg;
  assign frame_done   = frame_done_reg;
  assign frame_error  = frame_error_reg;
  assign sample_count = sample_count_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_spectrogram_stream_receiver.sv
// Scoreboard bench for spectrogram_stream_receiver: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT pulses its valid outputs.
module tb_spectrogram_stream_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  serial_in;
  logic        serial_readout;
  logic        sending_data;
  logic [31:0] event_time;
  logic        time_valid;
  logic [2:0]  ch1_code;
  logic [2:0]  ch2_code;
  logic [8:0]  sample_idx;
  logic        sample_valid;
  logic        frame_done;
  logic        frame_error;
  logic [9:0]  sample_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit gap_mode = 1'b0;
  int gap_ctr = 0;

  logic [31:0] exp_time_q[$];
  logic [14:0] exp_sample_q[$];  // {idx[8:0], ch1[2:0], ch2[2:0]}
  logic [10:0] exp_frame_q[$];   // {error, count[9:0]}

  spectrogram_stream_receiver #(.MAX_SAMPLES(512)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .serial_readout (serial_readout),
    .sending_data   (sending_data),
    .event_time     (event_time),
    .time_valid     (time_valid),
    .ch1_code       (ch1_code),
    .ch2_code       (ch2_code),
    .sample_idx     (sample_idx),
    .sample_valid   (sample_valid),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .sample_count   (sample_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected pulse expected none at %0t", name, $time);
  endtask

  // Monitor: one line per observed transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (time_valid) begin
        $display("time   event_time=0x%08h", event_time);
        if (exp_time_q.size() == 0) unexpected("time_valid");
        else chk("event_time", 64'(event_time), 64'(exp_time_q.pop_front()));
      end
      if (sample_valid) begin
        if (exp_sample_q.size() == 0) unexpected("sample_valid");
        else chk("sample", 64'({sample_idx, ch1_code, ch2_code}), 64'(exp_sample_q.pop_front()));
      end
      if (frame_done) begin
        $display("frame  error=%0d count=%0d", frame_error, sample_count);
        if (exp_frame_q.size() == 0) unexpected("frame_done");
        else chk("frame", 64'({frame_error, sample_count}), 64'(exp_frame_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic sd, input logic sr, input logic [1:0] lanes);
    @(negedge clk);
    sending_data   = sd;
    serial_readout = sr;
    serial_in      = lanes;
  endtask

  task automatic tbit(input logic l0, input logic l1);
    if (gap_mode) begin
      gap_ctr++;
      if (gap_ctr % 5 == 0) repeat (3) drive(1'b1, 1'b0, 2'($urandom));
      else if (gap_ctr % 2 == 0) drive(1'b1, 1'b0, 2'($urandom));
    end
    drive(1'b1, 1'b1, {l1, l0});
  endtask

  task automatic send_time(input logic [31:0] t, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) tbit(t[i], 1'($urandom));
  endtask

  task automatic send_pair(input logic [2:0] c1, input logic [2:0] c2);
    for (int i = 2; i >= 0; i--) tbit(c1[i], c2[i]);
  endtask

  task automatic end_frame();
    drive(1'b0, 1'b0, 2'b00);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'b00);
  endtask

  task automatic nominal_frame();
    exp_time_q.push_back(32'h12345678);
    exp_sample_q.push_back({9'd0, 3'd5, 3'd2});
    exp_sample_q.push_back({9'd1, 3'd7, 3'd0});
    exp_sample_q.push_back({9'd2, 3'd1, 3'd6});
    exp_frame_q.push_back({1'b0, 10'd3});
    send_time(32'h12345678, 32);
    send_pair(3'd5, 3'd2);
    send_pair(3'd7, 3'd0);
    send_pair(3'd1, 3'd6);
    end_frame();
    idle(4);
  endtask

  initial begin
    reset = 1'b1; sending_data = 1'b0; serial_readout = 1'b0; serial_in = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_event_time", 64'(event_time), 64'd0);
    chk("reset_pulses", 64'({time_valid, sample_valid, frame_done, frame_error}), 64'd0);
    chk("reset_codes", 64'({ch1_code, ch2_code, sample_idx}), 64'd0);
    chk("reset_count_busy", 64'({sample_count, busy}), 64'd0);

    // Nominal, then the same frame with gaps on serial_readout.
    nominal_frame();
    gap_mode = 1'b1;
    nominal_frame();
    gap_mode = 1'b0;

    // Partial pair: 32 time bits + 4 data bits.
    exp_time_q.push_back(32'hA5A5A5A5);
    exp_sample_q.push_back({9'd0, 3'd3, 3'd4});
    exp_frame_q.push_back({1'b1, 10'd1});
    send_time(32'hA5A5A5A5, 32);
    send_pair(3'd3, 3'd4);
    tbit(1'b1, 1'b1);
    end_frame();
    idle(3);

    // Short timestamp: 20 bits only.
    exp_frame_q.push_back({1'b1, 10'd0});
    send_time(32'hDEADBEEF, 20);
    end_frame();
    idle(3);
    chk("short_busy", 64'(busy), 64'd0);

    // Overflow: 514 pairs, only 512 reported.
    exp_time_q.push_back(32'h00C0FFEE);
    for (int i = 0; i < 512; i++)
      exp_sample_q.push_back({9'(i), 3'(i % 8), 3'((i * 3) % 8)});
    exp_frame_q.push_back({1'b1, 10'd512});
    send_time(32'h00C0FFEE, 32);
    for (int i = 0; i < 514; i++) send_pair(3'(i % 8), 3'((i * 3) % 8));
    end_frame();
    idle(3);

    // Reset mid-frame during DATA, stream continues 10 bits afterwards.
    exp_time_q.push_back(32'h0F0F0F0F);
    exp_sample_q.push_back({9'd0, 3'd2, 3'd5});
    send_time(32'h0F0F0F0F, 32);
    send_pair(3'd2, 3'd5);
    tbit(1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; sending_data = 1'b1; serial_readout = 1'b1; serial_in = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_event_time", 64'(event_time), 64'd0);
    chk("midreset_pulses", 64'({time_valid, sample_valid, frame_done, frame_error}), 64'd0);
    chk("midreset_codes", 64'({ch1_code, ch2_code, sample_idx, sample_count}), 64'd0);
    chk("midreset_busy_skip", 64'(busy), 64'd1);
    for (int i = 0; i < 10; i++) tbit(1'(i), 1'(i + 1));
    end_frame();
    idle(2);
    chk("skip_exit_busy", 64'(busy), 64'd0);
    exp_time_q.push_back(32'h0BADF00D);
    exp_sample_q.push_back({9'd0, 3'd4, 3'd3});
    exp_sample_q.push_back({9'd1, 3'd6, 3'd6});
    exp_frame_q.push_back({1'b0, 10'd2});
    send_time(32'h0BADF00D, 32);
    send_pair(3'd4, 3'd3);
    send_pair(3'd6, 3'd6);
    end_frame();
    idle(3);

    // Back-to-back time-only frames with one low cycle between.
    exp_time_q.push_back(32'hFFFFFFFF);
    exp_frame_q.push_back({1'b0, 10'd0});
    exp_time_q.push_back(32'h00000001);
    exp_frame_q.push_back({1'b0, 10'd0});
    send_time(32'hFFFFFFFF, 32);
    end_frame();
    send_time(32'h00000001, 32);
    end_frame();
    idle(5);

    chk("leftover_time", 64'(exp_time_q.size()), 64'd0);
    chk("leftover_sample", 64'(exp_sample_q.size()), 64'd0);
    chk("leftover_frame", 64'(exp_frame_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spectrogram_stream_receiver.md
# spectrogram_stream_receiver

Receive-side counterpart of the spectrogram extractor's serial readout port. It sits on the host/FPGA side, clocked by the same serial readout clock. It deserializes the two-lane stream into one 32-bit event timestamp followed by pairs of 3-bit channel codes, and flags frames whose length or structure is inconsistent.

## Interface
Parameters:
- MAX_SAMPLES, 512, maximum number of sample pairs accepted per frame; also sets the sample_idx width.

Ports:
- clk  in  1  serial readout clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- serial_in  in  2  lane 0 carries time bits then ch1 bits; lane 1 carries ch2 bits.
- serial_readout  in  1  a valid bit is present on serial_in this cycle.
- sending_data  in  1  frame envelope; high for the whole frame.
- event_time  out  32  captured timestamp: day[31:27] hour[26:22] min[21:16] sec[15:10] millisec[9:0].
- time_valid  out  1  one-cycle pulse; event_time newly updated.
- ch1_code, ch2_code  out  3 each  decoded sample pair.
- sample_idx  out  9  index of the current pair, 0-based.
- sample_valid  out  1  one-cycle pulse; codes and idx newly updated.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_error  out  1  qualifies frame_done; frame was malformed.
- sample_count  out  10  pairs received in the frame; valid with frame_done.
- busy  out  1  state is not IDLE.

## Operation
- Accepted bit: sending_data=1 and serial_readout=1 in the same cycle. No other cycle shifts data.
- States:
  - IDLE: sending_data=1 -> TIME. The bit accepted in that same cycle is time bit 31.
  - TIME: shift lane 0 into a 32-bit shift register, MSB first; lane 1 is ignored. After the 32nd accepted bit, load event_time, pulse time_valid, go to DATA.
  - DATA: shift both lanes into 3-bit registers, MSB first. Every 3rd accepted bit completes a pair: load ch1_code/ch2_code and sample_idx, pulse sample_valid, increment the pair counter.
  - SKIP: waits for sending_data=0, then goes to IDLE. No outputs.
- Frame end: sending_data=0 while in TIME or DATA.
  - Pulse frame_done and output sample_count, then go to IDLE.
  - frame_error=1 if the frame ended in TIME (timestamp incomplete), or the bit counter within the triple is non-zero (partial pair, discarded), or overflow is set.
- Overflow: once MAX_SAMPLES pairs are received, further accepted bits set an overflow flag and are discarded. No further sample_valid pulses. sample_count saturates at MAX_SAMPLES.
- A time-only frame (exactly 32 bits, then end) is legal: frame_done=1, frame_error=0, sample_count=0.
- Reset, applied at any time:
  - All outputs go to 0; counters, shift registers and overflow are cleared.
  - State after reset: IDLE if sending_data=0, else SKIP. This prevents capturing a misaligned mid-frame stream.
- Simultaneous events: if sending_data falls in a cycle, no bit is accepted in that cycle. serial_readout is ignored whenever sending_data=0.
- Back-to-back frames: one low cycle of sending_data is sufficient. The IDLE->TIME transition can occur in the cycle right after frame_done.

## Timing
- All outputs are registered.
- time_valid: high exactly one cycle, in the cycle after the edge that samples the 32nd time bit. event_time holds its value until the next time capture.
- sample_valid: high one cycle, in the cycle after the edge that samples the 3rd bit of a pair. Codes and sample_idx hold until the next pair.
- frame_done and frame_error: high one cycle, in the cycle after the edge that samples sending_data=0. sample_count holds until the next frame start, where it clears to 0.
- Throughput: one bit per cycle when serial_readout is held high. Gaps of any length (serial_readout=0) are tolerated, with no timeout.
- Reset values: every output is 0; busy=1 if reset exits into SKIP.

## Test plan
- Nominal frame:
  - Stimulus: 0x12345678 MSB-first on lane 0, then pairs (5,2), (7,0), (1,6) with continuous serial_readout, then sending_data low.
  - Response: time_valid with event_time=0x12345678; three sample_valid pulses with idx 0,1,2 and matching codes; frame_done=1, frame_error=0, sample_count=3.
- Gapped bits:
  - Stimulus: same frame as the nominal case with serial_readout toggling 1/0 and random 3-cycle holes.
  - Response: identical outputs; lane values during gaps are ignored.
- Partial and short frames:
  - Stimulus (a): 32 time bits + 4 data bits, then end.
  - Response (a): one sample_valid, frame_error=1, sample_count=1.
  - Stimulus (b): only 20 time bits, then end.
  - Response (b): no time_valid, frame_error=1, sample_count=0.
- Overflow:
  - Stimulus: MAX_SAMPLES+2 pairs.
  - Response: exactly 512 sample_valid pulses, the last with idx=511; sample_count=512; frame_error=1.
- Reset mid-frame:
  - Stimulus: reset pulsed during DATA while sending_data stays high for 10 more bits, then low, then a clean frame.
  - Response: all outputs 0 after reset; no pulses until the clean frame, which decodes correctly.
- Back-to-back frames:
  - Stimulus: two time-only frames (0xFFFFFFFF, then 0x00000001) separated by one low cycle.
  - Response: two time_valid pulses with the correct values; two frame_done pulses, each with frame_error=0 and sample_count=0.
